// File: rtl/ram_copy_engine.sv
// Block-copy engine for the single-port data RAM.
// Each word takes two cycles: a READ into a buffer, then a WRITE of that buffer.
module ram_copy_engine #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 16,
    parameter int STRIDE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_copied,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [ADDR_W-1:0]  r_src, r_dst;
    logic [LEN_W-1:0]   r_len, r_idx, r_cnt;
    logic [DATA_W-1:0]  r_buf;
    logic [ADDR_W-1:0]  w_off;
    logic               w_last;

    // Offset arithmetic wraps naturally at ADDR_W bits.
    assign w_off  = ADDR_W'(r_idx) * ADDR_W'(STRIDE);
    assign w_last = (r_idx + LEN_W'(1)) == r_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (start) begin
                    r_src <= src_addr;
                    r_dst <= dst_addr;
                    r_len <= length;
                    r_idx <= '0;
                    r_cnt <= '0;
                end
                S_READ:  r_buf <= mem_rdata;
                S_WRITE: begin
                    r_idx <= r_idx + LEN_W'(1);
                    r_cnt <= r_cnt + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (length == '0) ? S_DONE : S_READ;
            S_READ:  w_next = S_WRITE;
            S_WRITE: w_next = w_last ? S_DONE : S_READ;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decode from registered state only, so no input-to-output path exists.
    always_comb begin
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_DONE);
        words_copied = r_cnt;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_address  = '0;
        mem_wdata    = '0;
        case (r_state)
            S_READ: begin
                mem_read    = 1'b1;
                mem_address = r_src + w_off;
            end
            S_WRITE: begin
                mem_write   = 1'b1;
                mem_address = r_dst + w_off;
                mem_wdata   = r_buf;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed bench for ram_copy_engine with a 64-word behavioural RAM.
module tb_ram_copy_engine;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [63:0] src_addr, dst_addr;
    logic [15:0] length;
    logic        busy, done, mem_read, mem_write;
    logic [15:0] words_copied;
    logic [63:0] mem_address, mem_wdata, mem_rdata;
    logic [63:0] ram [0:63];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_copy_engine dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done), .words_copied(words_copied),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem_read ? ram[mem_address[5:0]] : 64'd0;
    always @(posedge clk) if (mem_write) ram[mem_address[5:0]] <= mem_wdata;

    typedef struct {
        logic [63:0] src, dst;
        logic [15:0] len;
        int          exp_cyc;
        logic [63:0] exp_first, exp_last;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload();
        @(negedge clk);
        for (int i = 0; i < 64; i++) ram[i] = 64'(100 + i);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, ".busy"}, 64'(busy), 64'd0);
        chk({name, ".done"}, 64'(done), 64'd0);
        chk({name, ".rd_wr"}, {62'd0, mem_read, mem_write}, 64'd0);
        chk({name, ".addr"}, mem_address, 64'd0);
        chk({name, ".wdata"}, mem_wdata, 64'd0);
    endtask

    // Returns at the negedge of the done cycle (dcyc counted from E0), or dcyc=0 on timeout.
    task automatic run_copy(input logic [63:0] s, input logic [63:0] d, input logic [15:0] n,
                            output int dcyc, output int both);
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; length = n;
        @(negedge clk);
        start = 1'b0;
        dcyc = 0; both = 0;
        for (int c = 1; c <= 200 && dcyc == 0; c++) begin
            if (mem_read && mem_write) both++;
            if (done) dcyc = c;
            else @(negedge clk);
        end
    endtask

    vec_t vecs [4];
    int   dcyc, both, npulse;

    initial begin
        vecs[0] = '{src: 64'd0,  dst: 64'd10, len: 16'd3, exp_cyc: 7, exp_first: 64'd100, exp_last: 64'd102};
        vecs[1] = '{src: 64'd5,  dst: 64'd40, len: 16'd1, exp_cyc: 3, exp_first: 64'd105, exp_last: 64'd105};
        vecs[2] = '{src: 64'd30, dst: 64'd50, len: 16'd4, exp_cyc: 9, exp_first: 64'd130, exp_last: 64'd133};
        vecs[3] = '{src: 64'd1,  dst: 64'd2,  len: 16'd2, exp_cyc: 5, exp_first: 64'd101, exp_last: 64'd101};

        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
        for (int i = 0; i < 64; i++) ram[i] = 64'(100 + i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_idle_outputs("reset");
        chk("reset.words", 64'(words_copied), 64'd0);
        chk("reset.ram0", ram[0], 64'd100);

        // Basic copy with the hand-picked data words.
        @(negedge clk);
        ram[0] = 64'd5; ram[1] = 64'd684; ram[2] = 64'd7;
        run_copy(64'd0, 64'd10, 16'd3, dcyc, both);
        chk("basic.done_cyc", 64'(dcyc), 64'd7);
        @(negedge clk);
        chk("basic.r10", ram[10], 64'd5);
        chk("basic.r11", ram[11], 64'd684);
        chk("basic.r12", ram[12], 64'd7);
        chk("basic.r1_src", ram[1], 64'd684);
        chk("basic.words", 64'(words_copied), 64'd3);
        chk_idle_outputs("basic.after");

        foreach (vecs[v]) begin
            preload();
            run_copy(vecs[v].src, vecs[v].dst, vecs[v].len, dcyc, both);
            chk($sformatf("vec%0d.done_cyc", v), 64'(dcyc), 64'(vecs[v].exp_cyc));
            chk($sformatf("vec%0d.rw_both", v), 64'(both), 64'd0);
            @(negedge clk);
            chk($sformatf("vec%0d.busy_after", v), 64'(busy), 64'd0);
            chk($sformatf("vec%0d.words", v), 64'(words_copied), 64'(vecs[v].len));
            chk($sformatf("vec%0d.first", v), ram[vecs[v].dst[5:0]], vecs[v].exp_first);
            chk($sformatf("vec%0d.last", v), ram[6'(vecs[v].dst + 64'(vecs[v].len) - 64'd1)], vecs[v].exp_last);
            repeat (2) @(negedge clk);
            chk($sformatf("vec%0d.words_hold", v), 64'(words_copied), 64'(vecs[v].len));
        end

        // Zero length: one DONE cycle, no RAM traffic.
        @(negedge clk);
        start = 1'b1; length = 16'd0; src_addr = 64'd3; dst_addr = 64'd4;
        @(negedge clk);
        start = 1'b0;
        chk("zero.c1", {61'd0, busy, done, mem_read | mem_write}, 64'b110);
        chk("zero.words", 64'(words_copied), 64'd0);
        @(negedge clk);
        chk("zero.c2", {61'd0, busy, done, mem_read | mem_write}, 64'b000);

        // Start while busy must be ignored.
        preload();
        start = 1'b1; src_addr = 64'd0; dst_addr = 64'd20; length = 16'd2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; dst_addr = 64'd40;
        @(negedge clk);
        start = 1'b0;
        npulse = 0;
        for (int c = 0; c < 10; c++) begin
            if (done) npulse++;
            @(negedge clk);
        end
        chk("busy_start.pulses", 64'(npulse), 64'd1);
        chk("busy_start.r20", ram[20], 64'd100);
        chk("busy_start.r21", ram[21], 64'd101);
        chk("busy_start.r40", ram[40], 64'd140);

        // Source address wraps past the top of the address space.
        preload();
        start = 1'b1; src_addr = 64'hFFFF_FFFF_FFFF_FFFF; dst_addr = 64'd10; length = 16'd2;
        @(negedge clk);
        start = 1'b0;
        chk("wrap.rd0_addr", mem_address, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        chk("wrap.wr0_addr", mem_address, 64'd10);
        @(negedge clk);
        chk("wrap.rd1", {mem_read, mem_address[62:0]}, {1'b1, 63'd0});
        chk("wrap.rd1_top", 64'(mem_address[63]), 64'd0);
        repeat (3) @(negedge clk);
        chk("wrap.r11", ram[11], 64'd100);

        // Reset asserted during the WRITE of word 1 (cycle 4).
        preload();
        for (int i = 50; i < 54; i++) ram[i] = 64'hDEAD;
        start = 1'b1; src_addr = 64'd0; dst_addr = 64'd50; length = 16'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid.in_write", {63'd0, mem_write}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_idle_outputs("rst_mid");
        chk("rst_mid.words", 64'(words_copied), 64'd0);
        repeat (8) @(negedge clk);
        chk("rst_mid.r50", ram[50], 64'd100);
        chk("rst_mid.r51", ram[51], 64'd101);
        chk("rst_mid.r52", ram[52], 64'hDEAD);
        chk("rst_mid.r53", ram[53], 64'hDEAD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_copy_engine.md
# ram_copy_engine

Initiator-side controller for the single-port data RAM (address, read, write, write-data, read-data interface). On a start command it copies a block of doublewords from a source word address to a destination word address. It drives the RAM's read and write strobes itself, so memory-to-memory moves in the LEGv8 single-cycle system do not need CPU load/store loops. It sits between the control logic and the RAM and owns the RAM port while busy.

## Interface
Parameters:
- ADDR_W, 64, width of RAM address and of src/dst addresses
- DATA_W, 64, RAM data width (one doubleword)
- LEN_W, 16, width of the transfer length in words
- STRIDE, 1, address increment per word (RAM is word-addressed)

Ports:
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high reset
- start  in  1  command strobe, sampled only in IDLE
- src_addr  in  ADDR_W  first source word address, captured on accepted start
- dst_addr  in  ADDR_W  first destination word address, captured on accepted start
- length  in  LEN_W  number of words to copy, captured on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the transfer completes
- words_copied  out  LEN_W  count of words written in the current or last transfer
- mem_address  out  ADDR_W  RAM address
- mem_read  out  1  RAM read enable
- mem_write  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, combinational from mem_address while mem_read=1

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: start=1 captures src, dst, and length into internal registers, clears the index i and words_copied, and moves to DONE if length==0, otherwise to READ. When start=0 the FSM stays in IDLE.
- READ: mem_read=1, mem_address=src+i*STRIDE. mem_rdata is latched into the data buffer at the clock edge, then the FSM moves to WRITE.
- WRITE: mem_write=1, mem_address=dst+i*STRIDE, mem_wdata=buffer. At the edge, i and words_copied increment. The FSM goes to DONE if i+1==length, otherwise to READ.
- DONE: done=1 for exactly this cycle, then the FSM returns to IDLE.
- All memory-side outputs and status outputs decode only from registered state; no combinational path from any input to any output.
- mem_read and mem_write are never high in the same cycle. mem_address, mem_wdata and mem_write stay stable for the whole WRITE cycle, because the RAM write is level-sensitive.
- Outside READ and WRITE, mem_read=0, mem_write=0, mem_address=0 and mem_wdata=0.
- Address arithmetic is modulo 2^ADDR_W: an address past the top wraps to 0 with no error.
- Copy order is ascending. Overlapping regions are copied word by word in that order with no overlap correction. For example, with dst=src+1 every destination word receives the original src[0].
- start while busy=1 is ignored; captured operands do not change mid-transfer.
- words_copied holds its final value in IDLE until the next accepted start.

## Timing
- Reset: at the first edge with reset=1 the FSM enters IDLE. busy=0, done=0, mem_read=0, mem_write=0, mem_address=0, mem_wdata=0, words_copied=0, and the internal registers are cleared.
- Reset mid-transfer aborts at that edge. Words already written stay in RAM, and no further write occurs.
- Call the edge that accepts start E0. For length N≥1:
  - Word k is in READ during cycle 2k+1 and in WRITE during cycle 2k+2, counted from E0.
  - done is high in cycle 2N+1.
  - busy is high in cycles 1 through 2N+1.
  - The next start is accepted no earlier than the edge ending cycle 2N+2.
- For length 0, busy and done are both high in cycle 1, with no RAM access.
- Throughput is 2 cycles per word.

## Test plan
- Reset check: preload RAM, hold reset for 2 cycles, release. Required: all outputs 0, FSM in IDLE, RAM unchanged.
- Basic copy: RAM[0]=5, RAM[1]=684, RAM[2]=7; start with src=0, dst=10, length=3. Required: RAM[10..12]=5, 684, 7; done in cycle 7 after E0; words_copied=3; sources unchanged.
- Zero length: start with length=0. Required: busy and done high in cycle 1 only; mem_read and mem_write never asserted.
- Start while busy: start with src=0, dst=20, length=2, and pulse start again in cycle 2 with dst=40. Required: only RAM[20..21] written, RAM[40] untouched, exactly one done pulse.
- Overlap and wrap:
  - Case A: RAM[0]=1, RAM[1]=2, start with src=0, dst=1, length=2. Required: RAM[1]=1, RAM[2]=1.
  - Case B: start with src=2^64−1, length=2. Required: the second read address is 0.
- Reset mid-transfer: start a length-4 copy and assert reset during the WRITE of word 1. Required: only word 0 and word 1 destinations are written, then all outputs return to 0 at the next edge.
